// File: rtl/contador_ciclo_etapa.sv
// Cycle/stage sequencer for the parallel FFT: N cycles per stage, NUM_ETAPAS stages per frame.
// Defining CONTADOR_CONTINUO_EN makes it free-run from reset, wrapping frames without start.
module contador_ciclo_etapa #(
    parameter int unsigned N          = 4,
    parameter int unsigned W          = 2,
    parameter int unsigned NUM_ETAPAS = 7,
    parameter int unsigned WE         = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          en,
    output logic [W-1:0]  num_ciclo,
    output logic [WE-1:0] num_etapa,
    output logic          busy,
    output logic          fin_etapa,
    output logic          done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    localparam logic [W-1:0]  CICLO_ULT = W'(N - 1);
    localparam logic [WE-1:0] ETAPA_ULT = WE'(NUM_ETAPAS - 1);

    logic [1:0]    estado_q, estado_d;
    logic [W-1:0]  ciclo_q, ciclo_d;
    logic [WE-1:0] etapa_q, etapa_d;
    logic          done_q, done_d;
    logic          ultimo_ciclo;

    assign ultimo_ciclo = (ciclo_q == CICLO_ULT);

    always_comb begin
        estado_d = estado_q;
        ciclo_d  = ciclo_q;
        etapa_d  = etapa_q;
        done_d   = 1'b0;
        case (estado_q)
            IDLE: begin
                ciclo_d = '0;
                etapa_d = '0;
`ifdef CONTADOR_CONTINUO_EN
                estado_d = RUN;
`else
                if (start) begin
                    estado_d = RUN;
                end
`endif
            end
            RUN: begin
                if (en) begin
                    if (ultimo_ciclo) begin
                        ciclo_d = '0;
                        if (etapa_q == ETAPA_ULT) begin
                            // Frame complete; in continuous mode the pulse overlaps the next frame
                            etapa_d = '0;
                            done_d  = 1'b1;
`ifndef CONTADOR_CONTINUO_EN
                            estado_d = DONE_ST;
`endif
                        end else begin
                            etapa_d = etapa_q + 1'b1;
                        end
                    end else begin
                        ciclo_d = ciclo_q + 1'b1;
                    end
                end
            end
            DONE_ST: begin
                ciclo_d  = '0;
                etapa_d  = '0;
                estado_d = start ? RUN : IDLE;
            end
            default: begin
                estado_d = IDLE;
                ciclo_d  = '0;
                etapa_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            estado_q <= IDLE;
            ciclo_q  <= '0;
            etapa_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            ciclo_q  <= ciclo_d;
            etapa_q  <= etapa_d;
            done_q   <= done_d;
        end
    end

    assign num_ciclo = ciclo_q;
    assign num_etapa = etapa_q;
    assign busy      = (estado_q == RUN);
    assign done      = done_q;
    assign fin_etapa = busy & en & ultimo_ciclo;

endmodule

// File: tb/tb_contador_ciclo_etapa.sv
// Directed bench for contador_ciclo_etapa (start-driven build): N=4/NUM_ETAPAS=3 and N=1/NUM_ETAPAS=4.
module tb_contador_ciclo_etapa;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start1;
    logic       en;
    logic [1:0] num_ciclo;
    logic [1:0] num_etapa;
    logic       busy, fin_etapa, done;
    logic [0:0] ciclo1;
    logic [1:0] etapa1;
    logic       busy1, fin1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    contador_ciclo_etapa #(.N(4), .W(2), .NUM_ETAPAS(3), .WE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .en        (en),
        .num_ciclo (num_ciclo),
        .num_etapa (num_etapa),
        .busy      (busy),
        .fin_etapa (fin_etapa),
        .done      (done)
    );

    contador_ciclo_etapa #(.N(1), .W(1), .NUM_ETAPAS(4), .WE(2)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .en        (en),
        .num_ciclo (ciclo1),
        .num_etapa (etapa1),
        .busy      (busy1),
        .fin_etapa (fin1),
        .done      (done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one N=4/3-stage frame from IDLE; optional stall of stall_len cycles at busy cycle stall_at.
    task automatic frame(input int stall_at, input int stall_len, input bit b2b);
        int k;
        int stalls;
        int busy_cnt;
        int n;
        start = 1'b1;
        en    = 1'b1;
        tick();
        start    = 1'b0;
        k        = 1;
        stalls   = 0;
        busy_cnt = 0;
        while (k <= 12) begin
            en = !(k == stall_at && stalls < stall_len);
            #1;
            check("busy", busy, 1);
            check("ciclo", num_ciclo, (k - 1) % 4);
            check("etapa", num_etapa, (k - 1) / 4);
            check("fin", fin_etapa, (en && (k % 4 == 0)) ? 1 : 0);
            check("done_run", done, 0);
            busy_cnt++;
            tick();
            if (en) k++;
            else stalls++;
        end
        en = 1'b1;
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("ciclo_done", num_ciclo, 0);
        check("etapa_done", num_etapa, 0);
        check("busy_cycles", busy_cnt, 12 + stall_len);
        if (b2b) start = 1'b1;
        tick();
        start = 1'b0;
        check("done_single", done, 0);
        if (b2b) begin
            check("b2b_busy", busy, 1);
            check("b2b_ciclo", num_ciclo, 0);
            check("b2b_etapa", num_etapa, 0);
            n = 0;
            while (!done && n < 20) begin
                tick();
                n++;
            end
            check("b2b_len", n, 12);
            tick();
            check("b2b_idle", busy, 0);
        end else begin
            check("idle_busy", busy, 0);
        end
    endtask

    initial begin
        rst    = 1'b0;
        start  = 1'b1;
        start1 = 1'b0;
        en     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ciclo", num_ciclo, 0);
            check("rst_etapa", num_etapa, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_busy1", busy1, 0);
        end
        rst   = 1'b1;
        start = 1'b0;
        tick();
        check("idle_after_rst", busy, 0);

        frame(0, 0, 1'b0);
        frame(7, 3, 1'b0);

        // Abort mid-frame at etapa 1, ciclo 2
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("abort_pre_ciclo", num_ciclo, 2);
        check("abort_pre_etapa", num_etapa, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_ciclo", num_ciclo, 0);
        check("abort_etapa", num_etapa, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tick();
        check("abort_no_done", done, 0);
        check("abort_idle", busy, 0);
        frame(0, 0, 1'b0);

        frame(0, 0, 1'b1);

        // N=1 degenerate instance
        start1 = 1'b1;
        en     = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("n1_busy", busy1, 1);
            check("n1_ciclo", ciclo1, 0);
            check("n1_etapa", etapa1, k);
            check("n1_fin", fin1, 1);
            check("n1_done_run", done1, 0);
            tick();
        end
        check("n1_done", done1, 1);
        check("n1_busy_done", busy1, 0);
        tick();
        check("n1_idle", busy1, 0);
        check("n1_done_single", done1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/contador_ciclo_etapa.md
Name: contador_ciclo_etapa

Overview:
- Parametrised cycle/stage sequencer for the parallel FFT datapath; successor of the fixed modulo-N cycle counter.
- Counts N cycles per stage and NUM_ETAPAS stages per frame, with start/enable control and stage/frame completion flags.
- Drives butterfly twiddle selection (num_ciclo) and stage muxing (num_etapa) in the top-level FFT.

Parameters:
- N, 4, cycles per stage (>=1).
- W, 2, width of num_ciclo; must satisfy 2^W >= N (W>=1).
- NUM_ETAPAS, 7, stages per frame (>=1).
- WE, 3, width of num_etapa; must satisfy 2^WE >= NUM_ETAPAS (WE>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  one-cycle frame launch request.
- en  input  1  advance enable; 0 freezes counters while busy.
- num_ciclo  output  W  cycle index within current stage, 0..N-1.
- num_etapa  output  WE  current stage index, 0..NUM_ETAPAS-1.
- busy  output  1  frame in progress.
- fin_etapa  output  1  combinational; high on the last enabled cycle of a stage.
- done  output  1  registered one-cycle frame-complete pulse.

Behaviour:
- Single clock, synchronous active-low reset; all state is registered except fin_etapa.
- Reset (rst=0 at an edge): state IDLE, num_ciclo=0, num_etapa=0, busy=0, done=0. This applies mid-frame: the frame is aborted and no done pulse is generated.
- States: IDLE, RUN, DONE.
- IDLE:
  - Counters held at 0; busy=0, done=0.
  - start=1 -> RUN at the next edge with num_ciclo=0, num_etapa=0, busy=1.
- RUN:
  - busy=1. en=0 holds all counters.
  - en=1 and num_ciclo<N-1: num_ciclo+1.
  - en=1 and num_ciclo==N-1: num_ciclo<=0. If num_etapa<NUM_ETAPAS-1, num_etapa+1; otherwise go to DONE with num_etapa<=0.
  - start is ignored in RUN.
- fin_etapa = busy & en & (num_ciclo==N-1).
- DONE:
  - Lasts exactly one cycle; done=1, busy=0, counters 0.
  - start=1 in DONE -> RUN directly (back-to-back frames). Otherwise -> IDLE.
- N=1: num_ciclo stays 0; every enabled RUN cycle completes a stage.
- Latency: first counted cycle is the one after start; a frame with en held high occupies exactly N*NUM_ETAPAS busy cycles.
- Width rules:
  - num_ciclo compares against N-1 truncated to W bits.
  - Counters never exceed N-1 or NUM_ETAPAS-1; no modular wrap beyond those bounds is possible.

Optional Feature:
- Macro: CONTADOR_CONTINUO_EN.
- Defined:
  - After reset the block enters RUN automatically at the first edge with rst=1; start is ignored.
  - On completing the last stage it wraps to num_etapa=0, num_ciclo=0 and stays in RUN, with busy constantly 1.
  - done pulses for one cycle concurrently with the first cycle of the new frame. The DONE state is not used.
- Undefined: start-driven behaviour exactly as above.

Test Plan (N=4, W=2, NUM_ETAPAS=3, WE=2 unless noted):
- Reset: rst=0 for 2 cycles with start=1, en=1 -> num_ciclo=0, num_etapa=0, busy=0, done=0 throughout.
- Single frame: start pulse, en=1 -> num_ciclo 0,1,2,3 repeated with num_etapa 0,1,2; busy high 12 cycles; fin_etapa on busy cycles 4, 8, 12; done=1 on cycle 13; IDLE on cycle 14.
- Stall: en=0 for 3 cycles at num_etapa=1, num_ciclo=2 -> values frozen, fin_etapa=0; busy lasts 15 cycles total; done still single-cycle.
- Abort: rst=0 at num_etapa=1, num_ciclo=2 -> next edge all outputs 0, no done. A later start runs a full 12-cycle frame.
- Degenerate and back-to-back:
  - N=1, W=1, NUM_ETAPAS=4: num_ciclo stays 0; num_etapa 0,1,2,3; fin_etapa every busy cycle; done after 4 busy cycles.
  - start asserted during DONE -> RUN next cycle with no IDLE gap.
- CONTADOR_CONTINUO_EN defined: release reset -> counting starts without start; done=1 at cycles 13, 25, ... coincident with num_etapa=0, num_ciclo=0; busy never drops.
